// File: rtl/sc_mnist_inference_ctrl.sv
// -----------------------------------------------------------------------------
// sc_mnist_inference_ctrl
// Sequencer for the stochastic-computing MNIST network (784-128-10, APC
// neurons). One inference is: clear the network and SNGs for one cycle,
// run WARMUP cycles to flush the network pipeline, accumulate STREAM_LEN
// cycles of output bitstream 1s per class, then scan the per-class counters
// sequentially (one per cycle) to find the argmax. Ties go to the lowest class.
//
// Optional feature: define SC_CTRL_ABORT_EN to add the 'abort' input, which
// returns any busy state to IDLE at the next edge without a done pulse.
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   start        request an inference (sampled only in IDLE)
//   abort        (SC_CTRL_ABORT_EN only) cancel the running inference
//   net_dout     per-class network output bitstreams
//   net_clear    synchronous clear to network state and SNG seeds
//   sng_en       SNG advance / stream generation enable
//   busy         high in every state except IDLE
//   done         one-cycle pulse when class_idx/class_count are updated
//   class_idx    argmax class of the last completed inference
//   class_count  1s-count of the winning class
// -----------------------------------------------------------------------------
module sc_mnist_inference_ctrl #(
  parameter int N2         = 10,
  parameter int STREAM_LEN = 256,
  parameter int WARMUP     = 2,
  parameter int CNT_W      = 9,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SC_CTRL_ABORT_EN
  input  logic             abort,
`endif
  input  logic [N2-1:0]    net_dout,
  output logic             net_clear,
  output logic             sng_en,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] class_idx,
  output logic [CNT_W-1:0] class_count
);

  localparam int WU_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_WARMUP = 3'd2,
    S_ACCUM  = 3'd3,
    S_ARGMAX = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q [N2];
  logic [CNT_W-1:0] rem_q;        // ACCUM cycles remaining after this one
  logic [WU_W-1:0]  wu_q;         // WARMUP cycles remaining after this one
  logic [IDX_W-1:0] scan_q;       // argmax scan index
  logic [IDX_W-1:0] best_idx_q;
  logic [CNT_W-1:0] best_cnt_q;
  logic [IDX_W-1:0] best_idx_d;
  logic [CNT_W-1:0] best_cnt_d;
  logic             net_clear_q;
  logic             sng_en_q;
  logic             busy_q;
  logic             done_q;
  logic [IDX_W-1:0] class_idx_q;
  logic [CNT_W-1:0] class_count_q;

  // Running argmax including the class under scan this cycle; strict compare
  // keeps the earliest (lowest) index on ties.
  always_comb begin
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    if (scan_q == {IDX_W{1'b0}}) begin
      best_idx_d = {IDX_W{1'b0}};
      best_cnt_d = cnt_q[0];
    end else if (cnt_q[scan_q] > best_cnt_q) begin
      best_idx_d = scan_q;
      best_cnt_d = cnt_q[scan_q];
    end else begin
      best_idx_d = best_idx_q;
      best_cnt_d = best_cnt_q;
    end
  end

  // Inference FSM with registered control outputs and datapath counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      for (int i = 0; i < N2; i++) cnt_q[i] <= {CNT_W{1'b0}};
      rem_q         <= {CNT_W{1'b0}};
      wu_q          <= {WU_W{1'b0}};
      scan_q        <= {IDX_W{1'b0}};
      best_idx_q    <= {IDX_W{1'b0}};
      best_cnt_q    <= {CNT_W{1'b0}};
      net_clear_q   <= 1'b0;
      sng_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      class_idx_q   <= {IDX_W{1'b0}};
      class_count_q <= {CNT_W{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_CLEAR;
            net_clear_q <= 1'b1;
            busy_q      <= 1'b1;
            for (int i = 0; i < N2; i++) cnt_q[i] <= {CNT_W{1'b0}};
          end
        end
        S_CLEAR: begin
          net_clear_q <= 1'b0;
          sng_en_q    <= 1'b1;
          if (WARMUP == 0) begin
            state_q <= S_ACCUM;
            rem_q   <= CNT_W'(STREAM_LEN - 1);
          end else begin
            state_q <= S_WARMUP;
            wu_q    <= WU_W'(WARMUP - 1);
          end
        end
        S_WARMUP: begin
          // net_dout is deliberately not observed: pipeline still filling
          if (wu_q == {WU_W{1'b0}}) begin
            state_q <= S_ACCUM;
            rem_q   <= CNT_W'(STREAM_LEN - 1);
          end else begin
            wu_q <= wu_q - WU_W'(1);
          end
        end
        S_ACCUM: begin
          for (int i = 0; i < N2; i++) begin
            if (net_dout[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
          if (rem_q == {CNT_W{1'b0}}) begin
            state_q  <= S_ARGMAX;
            sng_en_q <= 1'b0;
            scan_q   <= {IDX_W{1'b0}};
          end else begin
            rem_q <= rem_q - CNT_W'(1);
          end
        end
        S_ARGMAX: begin
          best_idx_q <= best_idx_d;
          best_cnt_q <= best_cnt_d;
          if (scan_q == IDX_W'(N2 - 1)) begin
            // Results include the final scanned class, hence the _d values
            state_q       <= S_DONE;
            done_q        <= 1'b1;
            class_idx_q   <= best_idx_d;
            class_count_q <= best_cnt_d;
          end else begin
            scan_q <= scan_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          net_clear_q <= 1'b0;
          sng_en_q    <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
`ifdef SC_CTRL_ABORT_EN
      // Abort overrides every busy-state update, including the result load
      if (abort && (state_q != S_IDLE)) begin
        state_q       <= S_IDLE;
        net_clear_q   <= 1'b0;
        sng_en_q      <= 1'b0;
        busy_q        <= 1'b0;
        done_q        <= 1'b0;
        class_idx_q   <= class_idx_q;
        class_count_q <= class_count_q;
      end
`endif
    end
  end

  assign net_clear   = net_clear_q;
  assign sng_en      = sng_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign class_idx   = class_idx_q;
  assign class_count = class_count_q;

endmodule

// File: tb/tb_sc_mnist_inference_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for sc_mnist_inference_ctrl. Stimulus vectors are
// generated per cycle (fixed and $urandom-based patterns); a reference model
// counts 1s only in the cycles that fall inside the accumulation window
// derived from the start edge, then takes the lowest-index maximum.
// -----------------------------------------------------------------------------
module tb_sc_mnist_inference_ctrl;

  localparam int N2  = 10;
  localparam int SL  = 256;
  localparam int WU  = 2;
  localparam int CW  = 9;
  localparam int IW  = 4;
  localparam int LAT = 1 + WU + SL + N2;   // edges from start sample to done

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [N2-1:0] net_dout;
  logic          net_clear;
  logic          sng_en;
  logic          busy;
  logic          done;
  logic [IW-1:0] class_idx;
  logic [CW-1:0] class_count;
`ifdef SC_CTRL_ABORT_EN
  logic          abort = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int prob [N2];
  int twin_a = 0;
  int twin_b = 1;

  sc_mnist_inference_ctrl #(
    .N2(N2), .STREAM_LEN(SL), .WARMUP(WU), .CNT_W(CW), .IDX_W(IW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
`ifdef SC_CTRL_ABORT_EN
    .abort(abort),
`endif
    .net_dout(net_dout),
    .net_clear(net_clear),
    .sng_en(sng_en),
    .busy(busy),
    .done(done),
    .class_idx(class_idx),
    .class_count(class_count)
  );

  always #5 clk = ~clk;

  // Edge n (counted from the start-sampling edge) samples an ACCUM cycle
  function automatic bit in_acc(input int n);
    return (n >= WU + 2) && (n <= WU + SL + 1);
  endfunction

  // Vector driven before edge n for the given pattern
  function automatic logic [N2-1:0] gen_vec(input int pat, input int n);
    logic [N2-1:0] v;
    int a;
    a = n - (WU + 2);
    v = '0;
    case (pat)
      0: v[3] = 1'b1;
      1: begin v[2] = 1'b1; v[7] = 1'b1; end
      2: begin
        if (n >= 2 && n <= WU + 1) v = '1;
        else if (in_acc(n)) v = N2'(1);
        else v = 'x;
      end
      3: begin
        for (int i = 0; i < N2; i++) v[i] = ($urandom_range(0, 99) < prob[i]);
        v[twin_b] = v[twin_a];
      end
      4: v[9] = (a >= 0 && a < 128);
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic run_inf(input int pat, input bit hold, input bit pulses, input string tag);
    int cnt_m [N2];
    logic [N2-1:0] v;
    int best;
    bit exp_done, exp_sng;
    for (int i = 0; i < N2; i++) cnt_m[i] = 0;
    start = 1'b1;
    net_dout = gen_vec(pat, 0);
    @(posedge clk); #1;
    n_cmp++;
    if (net_clear !== 1'b1 || busy !== 1'b1 || sng_en !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL %s clear_entry: clr=%b busy=%b sng=%b done=%b required 1 1 0 0",
               tag, net_clear, busy, sng_en, done);
    end
    for (int n = 1; n <= LAT; n++) begin
      v = gen_vec(pat, n);
      net_dout = v;
      start = hold || (pulses && (n == 5 || n == 50 || n == 200));
      @(posedge clk); #1;
      if (in_acc(n)) begin
        for (int i = 0; i < N2; i++) if (v[i] === 1'b1) cnt_m[i]++;
      end
      exp_done = (n == LAT);
      exp_sng  = (n <= WU + SL);
      n_cmp++;
      if (busy !== 1'b1 || net_clear !== 1'b0 || done !== exp_done || sng_en !== exp_sng) begin
        n_err++;
        $display("FAIL %s ctrl@%0d: busy=%b clr=%b done=%b sng=%b required 1 0 %b %b",
                 tag, n, busy, net_clear, done, sng_en, exp_done, exp_sng);
      end
    end
    best = 0;
    for (int i = 1; i < N2; i++) if (cnt_m[i] > cnt_m[best]) best = i;
    n_cmp++;
    if (class_idx !== IW'(best) || class_count !== CW'(cnt_m[best])) begin
      n_err++;
      $display("FAIL %s result: idx=%0d cnt=%0d required idx=%0d cnt=%0d",
               tag, class_idx, class_count, best, cnt_m[best]);
    end
    start = hold;
    net_dout = N2'($urandom);
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s post_done: done=%b busy=%b required 0 0", tag, done, busy);
    end
    if (!hold) begin
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || class_idx !== IW'(best)) begin
        n_err++;
        $display("FAIL %s idle_hold: busy=%b done=%b idx=%0d required 0 0 %0d",
                 tag, busy, done, class_idx, best);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || net_clear !== 1'b0 || sng_en !== 1'b0 ||
        class_idx !== '0 || class_count !== '0) begin
      n_err++;
      $display("FAIL %s: busy=%b done=%b clr=%b sng=%b idx=%0d cnt=%0d required all 0",
               tag, busy, done, net_clear, sng_en, class_idx, class_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; net_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N2; i++) prob[i] = $urandom_range(0, 80);
      twin_a = $urandom_range(0, N2 - 2);
      twin_b = $urandom_range(twin_a + 1, N2 - 1);
      prob[twin_a] = 95;
      prob[twin_b] = 95;
      run_inf(3, 1'b0, 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    prob[0] = 30; prob[1] = 60;
    for (int i = 2; i < N2; i++) prob[i] = $urandom_range(0, 90);
    twin_a = 4; twin_b = 8;
    run_inf(3, 1'b1, 1'b0, "b2b_1");
    run_inf(1, 1'b1, 1'b0, "b2b_2");
    run_inf(0, 1'b0, 1'b0, "b2b_3");
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= WU + 1 + 100; n++) begin
      net_dout = N2'($urandom);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("after_mid_reset");
    run_inf(4, 1'b0, 1'b0, "rst_rerun");
  endtask

`ifdef SC_CTRL_ABORT_EN
  task automatic test_abort();
    bit seen_done;
    run_inf(0, 1'b0, 1'b0, "abort_pre");
    start = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || class_idx !== IW'(3)) begin
      n_err++;
      $display("FAIL abort_idle: busy=%b idx=%0d required 0 3", busy, class_idx);
    end
    start = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b1 || net_clear !== 1'b1) begin
      n_err++;
      $display("FAIL abort_start_wins: busy=%b clr=%b required 1 1", busy, net_clear);
    end
    abort = 1'b0; start = 1'b0;
    for (int n = 1; n <= WU + 1 + 20; n++) begin
      net_dout = N2'($urandom);
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || sng_en !== 1'b0 || net_clear !== 1'b0 || done !== 1'b0 ||
        class_idx !== IW'(3) || class_count !== CW'(256)) begin
      n_err++;
      $display("FAIL abort_accum: busy=%b sng=%b clr=%b done=%b idx=%0d cnt=%0d required 0 0 0 0 3 256",
               busy, sng_en, net_clear, done, class_idx, class_count);
    end
    seen_done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done) begin
      n_err++;
      $display("FAIL abort_no_done: activity seen after abort, required none");
    end
  endtask
`endif

  initial begin
    test_reset();
    run_inf(0, 1'b0, 1'b0, "onehot3");
    run_inf(1, 1'b0, 1'b0, "tie_2_7");
    run_inf(2, 1'b0, 1'b0, "warmup_ignored");
    run_inf(0, 1'b0, 1'b1, "start_while_busy");
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef SC_CTRL_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
